// File: rtl/bp_io_cmd_throttle.sv
`default_nettype none
// ============================================================================
// Module   : bp_io_cmd_throttle
// Purpose  : Registered buffer and credit limiter between the I/O CCE and the
//            I/O network. Uncached I/O commands are held in a small circular
//            FIFO and released only while fewer than max_outstanding_p
//            commands are awaiting a response. Returning responses are
//            registered through a one-entry buffer before reaching the CCE.
//            A response arriving with nothing outstanding sets a sticky error.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i           in   clock, all state on the rising edge
//   reset_n_i       in   asynchronous active-low reset
//   io_cmd_i        in   command from CCE
//   io_cmd_v_i      in   command valid
//   io_cmd_ready_o  out  command FIFO has space
//   io_cmd_o        out  command to network (FIFO head)
//   io_cmd_v_o      out  head valid and a credit is available
//   io_cmd_ready_i  in   network accepts the command
//   io_resp_i       in   response from network
//   io_resp_v_i     in   response valid
//   io_resp_yumi_o  out  response consumed this cycle
//   io_resp_o       out  registered response to CCE
//   io_resp_v_o     out  response buffer full
//   io_resp_yumi_i  in   CCE consumes the buffered response
//   outstanding_o   out  commands issued minus responses accepted
//   idle_o          out  nothing buffered and nothing outstanding
//   err_o           out  sticky: response accepted with nothing outstanding
// ============================================================================
module bp_io_cmd_throttle #(
  // Message width normally derived from the processor configuration.
  parameter  int cce_mem_msg_width_lp = 128,
  parameter  int cmd_els_p            = 2,
  parameter  int max_outstanding_p    = 4,
  localparam int cnt_width_lp         = $clog2(max_outstanding_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,

  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,

  output logic [cnt_width_lp-1:0]         outstanding_o,
  output logic                            idle_o,
  output logic                            err_o
);

  localparam int c_PTR_W  = (cmd_els_p > 1) ? $clog2(cmd_els_p) : 1;
  localparam int c_FCNT_W = $clog2(cmd_els_p + 1);

  localparam logic [c_PTR_W-1:0]      c_LAST_PTR = c_PTR_W'(cmd_els_p - 1);
  localparam logic [c_FCNT_W-1:0]     c_CMD_ELS  = c_FCNT_W'(cmd_els_p);
  localparam logic [cnt_width_lp-1:0] c_MAX_OUT  = cnt_width_lp'(max_outstanding_p);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [cce_mem_msg_width_lp-1:0] r_cmd_mem [cmd_els_p];
  logic [c_PTR_W-1:0]              r_wr_ptr;
  logic [c_PTR_W-1:0]              r_rd_ptr;
  logic [c_FCNT_W-1:0]             r_cmd_cnt;

  logic [cnt_width_lp-1:0]         r_out_cnt;
  logic                            r_err;

  logic [cce_mem_msg_width_lp-1:0] r_resp_data;
  logic                            r_resp_v;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic                    w_cmd_enq;
  logic                    w_cmd_deq;
  logic                    w_resp_acc;
  logic                    w_resp_drain;
  logic [cnt_width_lp-1:0] w_out_nxt;
  logic [c_FCNT_W-1:0]     w_cmd_cnt_nxt;

  // Both command-side outputs depend only on registered state, so there is
  // no combinational path from io_cmd_v_i or io_cmd_ready_i to them, and a
  // credit returned by a response only becomes visible on the next cycle.
  assign io_cmd_ready_o = (r_cmd_cnt < c_CMD_ELS);
  assign io_cmd_v_o     = (r_cmd_cnt != '0) && (r_out_cnt < c_MAX_OUT);
  assign io_cmd_o       = r_cmd_mem[r_rd_ptr];

  // The buffer can take a new response when empty or when it is being
  // drained in the same cycle, which gives full throughput.
  assign io_resp_yumi_o = io_resp_v_i & (~r_resp_v | io_resp_yumi_i);
  assign io_resp_o      = r_resp_data;
  assign io_resp_v_o    = r_resp_v;

  assign outstanding_o  = r_out_cnt;
  assign err_o          = r_err;
  assign idle_o         = (r_cmd_cnt == '0) && !r_resp_v && (r_out_cnt == '0);

  assign w_cmd_enq      = io_cmd_v_i & io_cmd_ready_o;
  assign w_cmd_deq      = io_cmd_v_o & io_cmd_ready_i;
  assign w_resp_acc     = io_resp_yumi_o;
  assign w_resp_drain   = io_resp_yumi_i & r_resp_v;

  always_comb begin
    w_cmd_cnt_nxt = r_cmd_cnt;
    if (w_cmd_enq && !w_cmd_deq) begin
      w_cmd_cnt_nxt = r_cmd_cnt + c_FCNT_W'(1);
    end else if (w_cmd_deq && !w_cmd_enq) begin
      w_cmd_cnt_nxt = r_cmd_cnt - c_FCNT_W'(1);
    end
  end

  // Issue is gated by the credit check, so the increment cannot overshoot.
  // A response with nothing outstanding leaves the counter at zero.
  always_comb begin
    w_out_nxt = r_out_cnt;
    if (w_cmd_deq && !w_resp_acc) begin
      w_out_nxt = r_out_cnt + cnt_width_lp'(1);
    end else if (w_resp_acc && !w_cmd_deq && (r_out_cnt != '0)) begin
      w_out_nxt = r_out_cnt - cnt_width_lp'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cmd_cnt <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
      r_resp_v  <= 1'b0;
    end else begin
      if (w_cmd_enq) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_cmd_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      r_cmd_cnt <= w_cmd_cnt_nxt;
      r_out_cnt <= w_out_nxt;

      if (w_resp_acc && (r_out_cnt == '0)) begin
        r_err <= 1'b1;
      end

      if (w_resp_acc) begin
        r_resp_v <= 1'b1;
      end else if (w_resp_drain) begin
        r_resp_v <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data registers: qualified by the valid state above, so no reset needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_cmd_enq) begin
      r_cmd_mem[r_wr_ptr] <= io_cmd_i;
    end
    if (w_resp_acc) begin
      r_resp_data <= io_resp_i;
    end
  end

endmodule
`default_nettype wire
